theta_stream: RTL and testbench

Parametrised, streaming column-parity (theta) unit for the encoder's 5×5×NPAGES state. Pages (25-bit z-slices) arrive one per handshake, and the block emits each page XORed with its own and the previous page's column parities. The wrap-around term for page 0 is taken from the last page, so page 0 is held and emitted last. A bypass mode passes pages through untouched, which the encoder uses on rounds that skip the parity step.

---
 rtl/keccak_pkg.sv | 32 +++
 rtl/theta_page.sv | 21 ++
 rtl/theta_stream.sv | 134 +++++++++++++
 tb/tb_theta_stream.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak encoder datapath: page geometry,
// theta-unit FSM states and the column-parity helper.
package keccak_pkg;

    localparam int unsigned PAGE_W = 25;

    typedef logic [0:PAGE_W-1] page_t;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        STREAM,
        WRAP,
        PASS,
        DRAIN
    } state_t;

    // Bit position of lane A[x][y] inside a 25-bit page.
    function automatic int unsigned idx(input int unsigned x, input int unsigned y);
        return 5 * y + x;
    endfunction

    function automatic logic [4:0] col_parity(input page_t p);
        logic [4:0] c;
        c = '0;
        for (int unsigned x = 0; x < 5; x++)
            for (int unsigned y = 0; y < 5; y++)
                c[x] = c[x] ^ p[idx(x, y)];
        return c;
    endfunction

endpackage

// File: rtl/theta_page.sv
// Combinational theta step for one page: mixes in its own column parity
// and the previous page's column parity; also exports its own parity.
module theta_page
    import keccak_pkg::*;
(
    input  logic [0:PAGE_W-1] page_i,
    input  logic [4:0]        cprev_i,
    output logic [0:PAGE_W-1] theta_o,
    output logic [4:0]        cpar_o
);

    always_comb begin
        cpar_o  = col_parity(page_i);
        theta_o = '0;
        for (int unsigned y = 0; y < 5; y++)
            for (int unsigned x = 0; x < 5; x++)
                theta_o[idx(x, y)] = page_i[idx(x, y)] ^ cpar_o[(x + 4) % 5]
                                   ^ cprev_i[(x + 1) % 5];
    end

endmodule

// File: rtl/theta_stream.sv
// Streaming theta unit: pages 1..NPAGES-1 are emitted as they arrive, page 0
// is held and emitted last once the wrap-around parity is known.
module theta_stream
    import keccak_pkg::*;
#(
    parameter int unsigned NPAGES = 64,
    parameter int unsigned ZW     = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cal_start,
    input  logic              bypass,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:PAGE_W-1] page_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:PAGE_W-1] page_out,
    output logic [ZW-1:0]     z_out,
    output logic              busy,
    output logic              cal_finish
);

    localparam logic [ZW-1:0] LAST = ZW'(NPAGES - 1);

    state_t            state_q;
    logic [ZW-1:0]     z_q;
    logic [4:0]        cprev_q;
    page_t             hold_q;
    logic              byp_q;
    logic              ov_q;
    page_t             pout_q;
    logic [ZW-1:0]     zout_q;
    logic              fin_q;

    logic              slot_free;
    logic              in_fire;
    logic              out_fire;
    page_t             th_in;
    page_t             th_out;
    logic [4:0]        th_par;

    assign out_fire  = ov_q && out_ready;
    assign slot_free = !ov_q || out_ready;
    assign in_fire   = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            FIRST:        in_ready = 1'b1;
            STREAM, PASS: in_ready = slot_free;
            default:      in_ready = 1'b0;
        endcase
    end

    // The single theta instance serves both the live input and the held page 0.
    assign th_in = (state_q == WRAP) ? hold_q : page_in;

    theta_page u_theta (
        .page_i  (th_in),
        .cprev_i (cprev_q),
        .theta_o (th_out),
        .cpar_o  (th_par)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            z_q     <= '0;
            cprev_q <= '0;
            hold_q  <= '0;
            byp_q   <= 1'b0;
            ov_q    <= 1'b0;
            pout_q  <= '0;
            zout_q  <= '0;
            fin_q   <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            if (out_fire)
                ov_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cal_start) begin
                        byp_q   <= bypass;
                        z_q     <= '0;
                        state_q <= bypass ? PASS : FIRST;
                    end
                end
                FIRST: begin
                    if (in_fire) begin
                        hold_q  <= page_in;
                        cprev_q <= th_par;
                        z_q     <= z_q + ZW'(1);
                        state_q <= (NPAGES == 1) ? WRAP : STREAM;
                    end
                end
                STREAM, PASS: begin
                    if (in_fire) begin
                        ov_q    <= 1'b1;
                        pout_q  <= byp_q ? page_in : th_out;
                        zout_q  <= z_q;
                        z_q     <= z_q + ZW'(1);
                        if (!byp_q)
                            cprev_q <= th_par;
                        if (z_q == LAST)
                            state_q <= byp_q ? DRAIN : WRAP;
                    end
                end
                WRAP: begin
                    if (slot_free) begin
                        ov_q    <= 1'b1;
                        pout_q  <= th_out;
                        zout_q  <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!ov_q || out_fire) begin
                        fin_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid  = ov_q;
    assign page_out   = pout_q;
    assign z_out      = zout_q;
    assign busy       = (state_q != IDLE);
    assign cal_finish = fin_q;

endmodule

// File: tb/tb_theta_stream.sv
// Self-checking bench for theta_stream: three instances (NPAGES=4,2,1) driven
// through a shared port set, checked against a behavioural page-order model.
module tb_theta_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        cal_start;
    logic        bypass;
    logic        in_valid;
    logic        out_ready;
    logic [0:24] page_in;
    int unsigned sel;

    logic cs4, cs2, cs1, iv4, iv2, iv1;
    logic ir4, ov4, bz4, fn4;
    logic ir2, ov2, bz2, fn2;
    logic ir1, ov1, bz1, fn1;
    logic [0:24] po4, po2, po1;
    logic [1:0]  zo4;
    logic [0:0]  zo2, zo1;

    logic        c_ir, c_ov, c_bz, c_fn;
    logic [0:24] c_po;
    int unsigned c_zo;

    int nchecks = 0;
    int nerrors = 0;

    typedef struct {
        logic [0:24] p;
        int unsigned z;
    } exp_t;

    exp_t        exp_q[$];
    logic [0:24] pages[64];

    always #5 clk = ~clk;

    assign cs4 = cal_start && (sel == 0);
    assign cs2 = cal_start && (sel == 1);
    assign cs1 = cal_start && (sel == 2);
    assign iv4 = in_valid && (sel == 0);
    assign iv2 = in_valid && (sel == 1);
    assign iv1 = in_valid && (sel == 2);

    theta_stream #(.NPAGES(4)) u4 (
        .clk(clk), .rst(rst), .cal_start(cs4), .bypass(bypass),
        .in_valid(iv4), .in_ready(ir4), .page_in(page_in),
        .out_valid(ov4), .out_ready(out_ready), .page_out(po4), .z_out(zo4),
        .busy(bz4), .cal_finish(fn4)
    );

    theta_stream #(.NPAGES(2)) u2 (
        .clk(clk), .rst(rst), .cal_start(cs2), .bypass(bypass),
        .in_valid(iv2), .in_ready(ir2), .page_in(page_in),
        .out_valid(ov2), .out_ready(out_ready), .page_out(po2), .z_out(zo2),
        .busy(bz2), .cal_finish(fn2)
    );

    theta_stream #(.NPAGES(1)) u1 (
        .clk(clk), .rst(rst), .cal_start(cs1), .bypass(bypass),
        .in_valid(iv1), .in_ready(ir1), .page_in(page_in),
        .out_valid(ov1), .out_ready(out_ready), .page_out(po1), .z_out(zo1),
        .busy(bz1), .cal_finish(fn1)
    );

    always_comb begin
        c_ir = ir4; c_ov = ov4; c_po = po4; c_zo = 32'(zo4); c_bz = bz4; c_fn = fn4;
        if (sel == 1) begin
            c_ir = ir2; c_ov = ov2; c_po = po2; c_zo = 32'(zo2); c_bz = bz2; c_fn = fn2;
        end else if (sel == 2) begin
            c_ir = ir1; c_ov = ov1; c_po = po1; c_zo = 32'(zo1); c_bz = bz1; c_fn = fn1;
        end
    end

    // Reference: out(x,y) = in(x,y) ^ parity(in, column x-1) ^ parity(prev, column x+1)
    function automatic logic [0:24] theta_ref(input logic [0:24] cur, input logic [0:24] prev);
        logic [0:24] r;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                logic b;
                b = cur[5 * y + x];
                for (int k = 0; k < 5; k++) begin
                    b = b ^ cur[5 * k + (x + 4) % 5] ^ prev[5 * k + (x + 1) % 5];
                end
                r[5 * y + x] = b;
            end
        end
        return r;
    endfunction

    task automatic build_expected(input int unsigned n, input bit byp);
        exp_t e;
        exp_q.delete();
        if (byp) begin
            for (int unsigned z = 0; z < n; z++) begin
                e.p = pages[z]; e.z = z; exp_q.push_back(e);
            end
        end else begin
            for (int unsigned z = 1; z < n; z++) begin
                e.p = theta_ref(pages[z], pages[z - 1]); e.z = z; exp_q.push_back(e);
            end
            e.p = theta_ref(pages[0], pages[n - 1]); e.z = 0; exp_q.push_back(e);
        end
    endtask

    task automatic run_pass(input int unsigned inst, input int unsigned n, input bit byp,
                            input bit full_rate, input string name);
        int          acc = 0;
        int          cyc = 0;
        int          acc0_cyc = -1;
        int          z0_cyc = -1;
        int          fin_cyc = -1;
        int          fins = 0;
        bit          stall = 0;
        logic [0:24] held_p = '0;
        int unsigned held_z = 0;
        exp_t        e;

        build_expected(n, byp);
        sel       = inst;
        bypass    = byp;
        cal_start = 1'b1;
        @(posedge clk); #1;
        cal_start = 1'b0;
        bypass    = 1'($urandom);
        nchecks++;
        if (c_bz !== 1'b1) begin
            nerrors++;
            $display("FAIL %s busy_after_start: got %b want 1", name, c_bz);
        end

        while (fins == 0 && cyc < 3000) begin
            in_valid  = (acc < int'(n)) && (full_rate || $urandom_range(0, 3) != 0);
            page_in   = (acc < int'(n)) ? pages[acc] : 25'($urandom);
            out_ready = full_rate || ($urandom_range(0, 2) != 0);
            cal_start = (cyc == 1);
            bypass    = 1'($urandom);
            @(negedge clk);
            if (stall) begin
                nchecks++;
                if (c_ov !== 1'b1 || c_po !== held_p || c_zo !== held_z) begin
                    nerrors++;
                    $display("FAIL %s stall_stable: got v=%b p=%h z=%0d want v=1 p=%h z=%0d",
                             name, c_ov, c_po, c_zo, held_p, held_z);
                end
            end
            if (c_ov === 1'b1 && out_ready) begin
                nchecks++;
                if (exp_q.size() == 0) begin
                    nerrors++;
                    $display("FAIL %s extra_output: got p=%h z=%0d want none", name, c_po, c_zo);
                end else begin
                    e = exp_q.pop_front();
                    if (c_po !== e.p || c_zo !== e.z) begin
                        nerrors++;
                        $display("FAIL %s output: got p=%h z=%0d want p=%h z=%0d",
                                 name, c_po, c_zo, e.p, e.z);
                    end
                end
                if (c_zo == 0 && z0_cyc < 0) z0_cyc = cyc;
            end
            stall  = (c_ov === 1'b1) && !out_ready;
            held_p = c_po;
            held_z = c_zo;
            if (in_valid && c_ir === 1'b1) begin
                if (acc == 0) acc0_cyc = cyc;
                acc++;
            end
            if (c_fn === 1'b1) begin
                fins++;
                fin_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        cal_start = 1'b0;
        in_valid  = 1'b0;

        nchecks++;
        if (fins != 1) begin
            nerrors++;
            $display("FAIL %s finish_timeout: got %0d pulses want 1", name, fins);
        end
        nchecks++;
        if (exp_q.size() != 0 || acc != int'(n)) begin
            nerrors++;
            $display("FAIL %s completeness: got %0d missing outputs, %0d accepted want 0 missing, %0d accepted",
                     name, exp_q.size(), acc, n);
        end
        if (full_rate && !byp) begin
            nchecks++;
            if (z0_cyc - acc0_cyc != int'(n) + 1 || fin_cyc - acc0_cyc != int'(n) + 2) begin
                nerrors++;
                $display("FAIL %s latency: got z0=+%0d fin=+%0d want z0=+%0d fin=+%0d",
                         name, z0_cyc - acc0_cyc, fin_cyc - acc0_cyc, n + 1, n + 2);
            end
        end
        @(negedge clk);
        nchecks++;
        if (c_fn !== 1'b0 || c_bz !== 1'b0 || c_ov !== 1'b0) begin
            nerrors++;
            $display("FAIL %s post_pass_idle: got fin=%b busy=%b ov=%b want 0 0 0",
                     name, c_fn, c_bz, c_ov);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string name);
        for (int unsigned i = 0; i < 3; i++) begin
            sel = i;
            #0;
            nchecks++;
            if (c_ov !== 1'b0 || c_po !== '0 || c_zo !== 0 || c_ir !== 1'b0 ||
                c_bz !== 1'b0 || c_fn !== 1'b0) begin
                nerrors++;
                $display("FAIL %s inst%0d: got ov=%b po=%h z=%0d ir=%b busy=%b fin=%b want all 0",
                         name, i, c_ov, c_po, c_zo, c_ir, c_bz, c_fn);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cal_start = 1'b0; bypass = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; page_in = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        for (int i = 0; i < 4; i++) pages[i] = '0;
        run_pass(0, 4, 1'b0, 1'b1, "zero4");
        pages[0] = '0; pages[0][0] = 1'b1; pages[1] = '0;
        run_pass(1, 2, 1'b0, 1'b1, "np2_page0");
        pages[0] = '0; pages[1] = '0; pages[1][0] = 1'b1;
        run_pass(1, 2, 1'b0, 1'b1, "np2_wrap");
        pages[0] = '0; pages[0][0] = 1'b1;
        run_pass(2, 1, 1'b0, 1'b1, "np1");
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 4; i++) pages[i] = 25'(i + 1);
        run_pass(0, 4, 1'b1, 1'b1, "bypass_fixed");
        for (int i = 0; i < 4; i++) pages[i] = 25'($urandom);
        run_pass(0, 4, 1'b1, 1'b0, "bypass_rand");
        pages[0] = 25'($urandom);
        run_pass(2, 1, 1'b1, 1'b0, "bypass_np1");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) pages[i] = 25'($urandom);
            run_pass(r % 3, (r % 3 == 0) ? 4 : (r % 3 == 1) ? 2 : 1, 1'b0, 1'b0, "theta_rand");
        end
        for (int i = 0; i < 4; i++) pages[i] = 25'($urandom);
        run_pass(0, 4, 1'b0, 1'b1, "theta_full");
    endtask

    task automatic test_reset_midpass();
        for (int i = 0; i < 4; i++) pages[i] = 25'($urandom);
        sel = 0; out_ready = 1'b1; bypass = 1'b0;
        cal_start = 1'b1;
        @(posedge clk); #1;
        cal_start = 1'b0;
        in_valid = 1'b1;
        page_in = pages[0];
        @(posedge clk); #1;
        page_in = pages[1];
        @(posedge clk); #1;
        page_in = pages[2];
        #2;
        nchecks++;
        if (c_ov !== 1'b1 || c_zo !== 1) begin
            nerrors++;
            $display("FAIL midpass_pre: got ov=%b z=%0d want ov=1 z=1", c_ov, c_zo);
        end
        rst = 1'b1;
        #1;
        check_reset_values("midpass_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        page_in = 25'($urandom);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nchecks++;
            if (c_ir !== 1'b0 || c_ov !== 1'b0 || c_bz !== 1'b0) begin
                nerrors++;
                $display("FAIL idle_in_valid: got ir=%b ov=%b busy=%b want 0 0 0", c_ir, c_ov, c_bz);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) pages[i] = 25'($urandom);
        run_pass(0, 4, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_bypass();
        test_random();
        test_reset_midpass();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
